segre_wb_stage: RTL and testbench
=================================

// Module: segre_wb_stage
// PURPOSE
//  Writeback stage directly downstream of the MEM stage. Holds the MEM/WB pipeline
//  register and owns the single register-file write port. That port is shared with a
//  long-latency unit (mul/div) through a valid/ready handshake and a 1-entry holding
//  buffer. Also provides the WB forwarding path and the retired-instruction counter.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive cycles the lat buffer may stay held before wb_stall_o asserts
//  CNT_WIDTH     64  width of the retired-instruction counter
// PORTS
//  clk_i          in   1          clock, rising edge
//  rsn_i          in   1          reset, asynchronous, active-low
//  valid_mem_i    in   1          MEM stage holds a valid instruction
//  op_res_i       in   WORD_SIZE  MEM result (load data / ALU / link PC)
//  rf_we_i        in   1          MEM instruction writes the RF
//  rf_waddr_i     in   REG_SIZE   destination register
//  block_wb_i     in   1          hold the MEM/WB register
//  inject_nops_i  in   1          load a bubble into the MEM/WB register
//  lat_valid_i    in   1          long-latency result available
//  lat_waddr_i    in   REG_SIZE   long-latency destination
//  lat_data_i     in   WORD_SIZE  long-latency result
//  lat_ready_o    out  1          result accepted this cycle (when lat_valid_i=1)
//  rf_we_o        out  1          RF write enable
//  rf_waddr_o     out  REG_SIZE   RF write address
//  rf_wdata_o     out  WORD_SIZE  RF write data
//  fwd_valid_o    out  1          forwarding valid; equals rf_we_o
//  fwd_waddr_o    out  REG_SIZE   forwarding address; equals rf_waddr_o
//  fwd_data_o     out  WORD_SIZE  forwarding data; equals rf_wdata_o
//  wb_stall_o     out  1          request upstream bubble to drain the lat buffer
//  instret_o      out  CNT_WIDTH  retired-instruction count
// BEHAVIOUR
//  Reset (async, rsn_i=0): valid_q=0, rf_we_q=0, waddr_q=0, res_q=0.
//   FSM=LAT_IDLE, starve_cnt=0, instret=0.
//   Outputs: rf_we_o=0, lat_ready_o=0 while in reset, wb_stall_o=0.
//  MEM/WB register, priority order:
//   block_wb_i: hold all fields.
//   inject_nops_i: valid_q=0, rf_we_q=0.
//   otherwise: capture the *_i fields.
//  pipe_wr = valid_q & rf_we_q & (waddr_q!=0). Register x0 is never written.
//  Write port is combinational from state. The pipeline has priority over the lat path.
//  FSM LAT_IDLE:
//   lat_ready_o=1.
//   lat_valid_i & !pipe_wr & lat_waddr_i!=0: write lat_* directly, same cycle; stay IDLE.
//   lat_valid_i & pipe_wr: capture lat_* into buffer; go to LAT_HELD.
//   lat_valid_i & lat_waddr_i==0: accept and drop; stay IDLE.
//  FSM LAT_HELD:
//   lat_ready_o=0.
//   !pipe_wr: write buffer; go to LAT_IDLE. The next lat can be accepted the following cycle.
//   pipe_wr: stay HELD, starve_cnt++ (saturating).
//  wb_stall_o=1 when state==HELD & starve_cnt>=STARVE_LIMIT.
//   The resulting upstream bubble guarantees !pipe_wr, so the buffer drains.
//   starve_cnt clears on entering IDLE.
//  Simultaneous pipe_wr and lat/buffer write are never both issued; the port writes at most one per cycle.
//  Same waddr on both paths in one cycle: the pipeline writes first, then the buffer.
//   Program order is the lat unit's concern; WB does not reorder.
//  instret increments by 1 when valid_q & !block_wb_i, including non-writing instructions.
//   Lat writebacks do not count. Wraps modulo 2^CNT_WIDTH.
//  Latency: MEM output to RF write is 1 cycle. Direct lat path is 0 cycles; buffered lat path is >=1 cycle.
//  A reset in the middle of LAT_HELD discards the buffered result. The lat unit must also be reset.
// STRUCTURE
//  segre_pkg additions: typedef enum logic {LAT_IDLE, LAT_HELD} wb_lat_state_e;
//   typedef struct {waddr, data} rf_wr_t.
//  Reuse WORD_SIZE and REG_SIZE from segre_pkg.
//  One sub-module: segre_wb_lat_buffer (FSM + 1-entry buffer + starve counter).
//  The MEM/WB register, write mux and instret stay in the top module.
// TESTING
//  1 ALU op x5=0x1234, valid, no block -> next cycle rf_we_o=1, waddr=5, wdata=0x1234, instret 0->1.
//  2 rf_waddr_i=0, rf_we_i=1 -> rf_we_o=0; instret still increments.
//  3 lat_valid_i x7=0xBEEF while pipe writes x3 -> rf writes x3; lat_ready_o=1; FSM HELD;
//    next idle cycle writes x7=0xBEEF.
//  4 HELD with pipe_wr for 4 cycles -> wb_stall_o=1 in cycle 5; bubble -> buffer written, back to IDLE.
//  5 block_wb_i for 3 cycles on a valid op -> instret +1 total; inject_nops_i -> no write.
//  6 rsn_i low during HELD -> rf_we_o=0, instret=0, FSM IDLE immediately (async).

Source files
------------

// File: rtl/segre_pkg.sv
// Shared SEGRE core types and sizes used by the writeback stage.
package segre_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 5;

  typedef enum logic {
    LAT_IDLE = 1'b0,
    LAT_HELD = 1'b1
  } wb_lat_state_e;

  typedef struct packed {
    logic [REG_SIZE-1:0]  waddr;
    logic [WORD_SIZE-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/segre_wb_lat_buffer.sv
// Long-latency result acceptance: direct write, 1-entry holding buffer and starvation guard.
//  state    | meaning
//  LAT_IDLE | buffer empty; lat result accepted, written now if the port is free
//  LAT_HELD | buffer full; waiting for a cycle without a pipeline write
module segre_wb_lat_buffer
  import segre_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  input  logic                pipe_wr_i,
  input  logic                lat_valid_i,
  input  logic [REG_SIZE-1:0] lat_waddr_i,
  input  logic [WORD_SIZE-1:0] lat_data_i,
  output logic                lat_ready_o,
  output logic                lat_we_o,
  output rf_wr_t              lat_wr_o,
  output logic                wb_stall_o
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  wb_lat_state_e state_q, state_d;
  rf_wr_t        buf_q, buf_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    starve_d    = starve_q;
    lat_we_o    = 1'b0;
    lat_wr_o    = buf_q;
    lat_ready_o = 1'b0;
    case (state_q)
      LAT_IDLE: begin
        lat_ready_o = rsn_i;
        // x0 results are accepted and silently dropped
        if (lat_valid_i && rsn_i && (lat_waddr_i != '0)) begin
          if (pipe_wr_i) begin
            buf_d.waddr = lat_waddr_i;
            buf_d.data  = lat_data_i;
            starve_d    = '0;
            state_d     = LAT_HELD;
          end else begin
            lat_we_o       = 1'b1;
            lat_wr_o.waddr = lat_waddr_i;
            lat_wr_o.data  = lat_data_i;
          end
        end
      end
      LAT_HELD: begin
        if (!pipe_wr_i) begin
          lat_we_o = 1'b1;
          starve_d = '0;
          state_d  = LAT_IDLE;
        end else if (starve_q < LIMIT) begin
          starve_d = starve_q + 1'b1;
        end
      end
      default: state_d = LAT_IDLE;
    endcase
    stall_d = (state_d == LAT_HELD) && (starve_d >= LIMIT);
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q  <= LAT_IDLE;
      buf_q    <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign wb_stall_o = stall_q;

endmodule

// File: rtl/segre_wb_stage.sv
// Writeback stage: MEM/WB register, shared RF write port, forwarding and retired count.
module segre_wb_stage
  import segre_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 valid_mem_i,
  input  logic [WORD_SIZE-1:0] op_res_i,
  input  logic                 rf_we_i,
  input  logic [REG_SIZE-1:0]  rf_waddr_i,
  input  logic                 block_wb_i,
  input  logic                 inject_nops_i,
  input  logic                 lat_valid_i,
  input  logic [REG_SIZE-1:0]  lat_waddr_i,
  input  logic [WORD_SIZE-1:0] lat_data_i,
  output logic                 lat_ready_o,
  output logic                 rf_we_o,
  output logic [REG_SIZE-1:0]  rf_waddr_o,
  output logic [WORD_SIZE-1:0] rf_wdata_o,
  output logic                 fwd_valid_o,
  output logic [REG_SIZE-1:0]  fwd_waddr_o,
  output logic [WORD_SIZE-1:0] fwd_data_o,
  output logic                 wb_stall_o,
  output logic [CNT_WIDTH-1:0] instret_o
);

  logic                 valid_q, valid_d;
  logic                 rf_we_q, rf_we_d;
  logic [REG_SIZE-1:0]  waddr_q, waddr_d;
  logic [WORD_SIZE-1:0] res_q, res_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;

  logic   pipe_wr;
  logic   lat_we;
  rf_wr_t lat_wr;

  always_comb begin
    valid_d = valid_q;
    rf_we_d = rf_we_q;
    waddr_d = waddr_q;
    res_d   = res_q;
    if (block_wb_i) begin
      valid_d = valid_q;
    end else if (inject_nops_i) begin
      valid_d = 1'b0;
      rf_we_d = 1'b0;
    end else begin
      valid_d = valid_mem_i;
      rf_we_d = rf_we_i;
      waddr_d = rf_waddr_i;
      res_d   = op_res_i;
    end
    // held instructions retire only once, on the cycle they leave WB
    instret_d = instret_q;
    if (valid_q && !block_wb_i) begin
      instret_d = instret_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      valid_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      waddr_q   <= '0;
      res_q     <= '0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rf_we_q   <= rf_we_d;
      waddr_q   <= waddr_d;
      res_q     <= res_d;
      instret_q <= instret_d;
    end
  end

  assign pipe_wr = valid_q && rf_we_q && (waddr_q != '0);

  segre_wb_lat_buffer #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_lat_buffer (
    .clk_i      (clk_i),
    .rsn_i      (rsn_i),
    .pipe_wr_i  (pipe_wr),
    .lat_valid_i(lat_valid_i),
    .lat_waddr_i(lat_waddr_i),
    .lat_data_i (lat_data_i),
    .lat_ready_o(lat_ready_o),
    .lat_we_o   (lat_we),
    .lat_wr_o   (lat_wr),
    .wb_stall_o (wb_stall_o)
  );

  // pipeline wins the port; the lat side only writes when pipe_wr is low
  always_comb begin
    rf_we_o    = pipe_wr || lat_we;
    rf_waddr_o = pipe_wr ? waddr_q : lat_wr.waddr;
    rf_wdata_o = pipe_wr ? res_q : lat_wr.data;
  end

  assign fwd_valid_o = rf_we_o;
  assign fwd_waddr_o = rf_waddr_o;
  assign fwd_data_o  = rf_wdata_o;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_segre_wb_stage.sv
// Self-checking bench for segre_wb_stage: directed vector table, corner sequences, random vs model.
module tb_segre_wb_stage;
  import segre_pkg::*;

  localparam int LIM = 4;

  logic                 clk_i = 1'b0;
  logic                 rsn_i;
  logic                 valid_mem_i, rf_we_i, block_wb_i, inject_nops_i, lat_valid_i;
  logic [WORD_SIZE-1:0] op_res_i, lat_data_i;
  logic [REG_SIZE-1:0]  rf_waddr_i, lat_waddr_i;
  logic                 lat_ready_o, rf_we_o, fwd_valid_o, wb_stall_o;
  logic [REG_SIZE-1:0]  rf_waddr_o, fwd_waddr_o;
  logic [WORD_SIZE-1:0] rf_wdata_o, fwd_data_o;
  logic [63:0]          instret_o;

  segre_wb_stage #(.STARVE_LIMIT(LIM), .CNT_WIDTH(64)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .valid_mem_i(valid_mem_i), .op_res_i(op_res_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .block_wb_i(block_wb_i),
    .inject_nops_i(inject_nops_i), .lat_valid_i(lat_valid_i), .lat_waddr_i(lat_waddr_i),
    .lat_data_i(lat_data_i), .lat_ready_o(lat_ready_o), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .fwd_valid_o(fwd_valid_o),
    .fwd_waddr_o(fwd_waddr_o), .fwd_data_o(fwd_data_o), .wb_stall_o(wb_stall_o),
    .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid, we, block, inject, lat_valid;
    logic [4:0]  waddr, lat_waddr;
    logic [31:0] res, lat_data;
  } in_t;

  typedef struct {
    in_t         i;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_ready, exp_stall;
    logic [63:0] exp_instret;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: pending lat results as a queue, plus what sits in WB
  logic        m_valid, m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_res;
  rf_wr_t      m_buf[$];
  int          m_starve;
  logic [63:0] m_instret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic v, input logic we, input logic [4:0] a,
                             input logic [31:0] r, input logic blk, input logic inj,
                             input logic lv, input logic [4:0] la, input logic [31:0] ld);
    in_t x;
    x.valid = v; x.we = we; x.waddr = a; x.res = r; x.block = blk; x.inject = inj;
    x.lat_valid = lv; x.lat_waddr = la; x.lat_data = ld;
    return x;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_waddr = 0; m_res = 0;
    m_buf.delete();
    m_starve = 0; m_instret = 0;
  endtask

  task automatic model_check();
    bit          pw, held, ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    pw   = m_valid && m_we && (m_waddr != 0);
    held = (m_buf.size() != 0);
    ew = 1'b0; ea = 0; ed = 0;
    if (pw) begin
      ew = 1'b1; ea = m_waddr; ed = m_res;
    end else if (held) begin
      ew = 1'b1; ea = m_buf[0].waddr; ed = m_buf[0].data;
    end else if (lat_valid_i && lat_waddr_i != 0) begin
      ew = 1'b1; ea = lat_waddr_i; ed = lat_data_i;
    end
    chk("m_rf_we", rf_we_o, ew);
    chk("m_fwd_valid", fwd_valid_o, ew);
    if (ew) begin
      chk("m_rf_waddr", rf_waddr_o, ea);
      chk("m_rf_wdata", rf_wdata_o, ed);
      chk("m_fwd_waddr", fwd_waddr_o, ea);
      chk("m_fwd_data", fwd_data_o, ed);
    end
    chk("m_lat_ready", lat_ready_o, !held);
    chk("m_wb_stall", wb_stall_o, held && (m_starve >= LIM));
    chk("m_instret", instret_o, m_instret);
  endtask

  task automatic model_update();
    bit pw;
    rf_wr_t e;
    pw = m_valid && m_we && (m_waddr != 0);
    if (m_buf.size() != 0) begin
      if (!pw) begin
        void'(m_buf.pop_front());
        m_starve = 0;
      end else begin
        m_starve++;
      end
    end else if (lat_valid_i && lat_waddr_i != 0 && pw) begin
      e.waddr = lat_waddr_i; e.data = lat_data_i;
      m_buf.push_back(e);
      m_starve = 0;
    end
    if (m_valid && !block_wb_i) m_instret = m_instret + 64'd1;
    if (block_wb_i) begin
    end else if (inject_nops_i) begin
      m_valid = 0; m_we = 0;
    end else begin
      m_valid = valid_mem_i; m_we = rf_we_i; m_waddr = rf_waddr_i; m_res = op_res_i;
    end
  endtask

  task automatic drive(input in_t v);
    valid_mem_i = v.valid; rf_we_i = v.we; rf_waddr_i = v.waddr; op_res_i = v.res;
    block_wb_i = v.block; inject_nops_i = v.inject;
    lat_valid_i = v.lat_valid; lat_waddr_i = v.lat_waddr; lat_data_i = v.lat_data;
  endtask

  // Drive one cycle's inputs, check outputs against the model, advance the model
  task automatic apply(input in_t v);
    @(negedge clk_i);
    drive(v);
    #1;
    model_check();
    model_update();
  endtask

  vec_t   vecs[8];
  in_t    idle;
  in_t    r;
  logic [63:0] base;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0] = '{mk(1, 1, 5, 32'h1234, 0, 0, 0, 0, 0),       0, 0, 0, 1, 0, 0};
    vecs[1] = '{mk(1, 1, 0, 32'h55, 0, 0, 0, 0, 0),         1, 5, 32'h1234, 1, 0, 0};
    vecs[2] = '{mk(1, 1, 3, 32'h3333, 0, 0, 0, 0, 0),       0, 0, 0, 1, 0, 1};
    vecs[3] = '{mk(0, 0, 0, 0, 0, 0, 1, 7, 32'hBEEF),       1, 3, 32'h3333, 1, 0, 2};
    vecs[4] = '{mk(0, 0, 0, 0, 0, 0, 1, 9, 32'h9999),       1, 7, 32'hBEEF, 0, 0, 3};
    vecs[5] = '{mk(0, 0, 0, 0, 0, 0, 1, 9, 32'h9999),       1, 9, 32'h9999, 1, 0, 3};
    vecs[6] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD),       0, 0, 0, 1, 0, 3};
    vecs[7] = '{idle,                                       0, 0, 0, 1, 0, 3};

    rsn_i = 1'b0;
    drive(idle);
    model_reset();
    #1;
    chk("rst_rf_we", rf_we_o, 0);
    chk("rst_lat_ready", lat_ready_o, 0);
    chk("rst_stall", wb_stall_o, 0);
    chk("rst_instret", instret_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rsn_i = 1'b1;

    // directed vector table
    for (int k = 0; k < 8; k++) begin
      apply(vecs[k].i);
      chk($sformatf("tbl%0d_we", k), rf_we_o, vecs[k].exp_we);
      if (vecs[k].exp_we) begin
        chk($sformatf("tbl%0d_waddr", k), rf_waddr_o, vecs[k].exp_waddr);
        chk($sformatf("tbl%0d_wdata", k), rf_wdata_o, vecs[k].exp_wdata);
      end
      chk($sformatf("tbl%0d_ready", k), lat_ready_o, vecs[k].exp_ready);
      chk($sformatf("tbl%0d_stall", k), wb_stall_o, vecs[k].exp_stall);
      chk($sformatf("tbl%0d_instret", k), instret_o, vecs[k].exp_instret);
    end

    // starvation: buffer held under continuous pipeline writes
    apply(mk(1, 1, 4, 32'h40, 0, 0, 0, 0, 0));
    apply(mk(1, 1, 4, 32'h41, 0, 0, 1, 8, 32'h8888));
    chk("starve_accept_ready", lat_ready_o, 1);
    for (int k = 1; k <= 4; k++) begin
      apply(mk(1, 1, 4, 32'h41 + k, 0, 0, 0, 0, 0));
      chk($sformatf("starve_c%0d_stall", k), wb_stall_o, 0);
      chk($sformatf("starve_c%0d_ready", k), lat_ready_o, 0);
    end
    apply(idle);
    chk("starve_c5_stall", wb_stall_o, 1);
    apply(idle);
    chk("starve_drain_we", rf_we_o, 1);
    chk("starve_drain_waddr", rf_waddr_o, 8);
    chk("starve_drain_wdata", rf_wdata_o, 32'h8888);
    apply(idle);
    chk("starve_after_stall", wb_stall_o, 0);
    chk("starve_after_ready", lat_ready_o, 1);

    // block holds the instruction; it retires once, then a bubble writes nothing
    apply(mk(1, 1, 6, 32'h66, 0, 0, 0, 0, 0));
    base = m_instret;
    for (int k = 0; k < 3; k++) begin
      apply(mk(1, 1, 10, 32'hA0 + k, 1, 0, 0, 0, 0));
      chk($sformatf("block%0d_waddr", k), rf_waddr_o, 6);
    end
    apply(mk(1, 1, 11, 32'hB0, 0, 1, 0, 0, 0));
    apply(idle);
    chk("block_instret", instret_o, base + 64'd1);
    chk("inject_no_write", rf_we_o, 0);

    // reset asserted mid-cycle while a result is held
    apply(mk(1, 1, 2, 32'h22, 0, 0, 0, 0, 0));
    apply(mk(1, 1, 2, 32'h23, 0, 0, 1, 9, 32'h9090));
    @(negedge clk_i);
    drive(idle);
    #2;
    rsn_i = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_we", rf_we_o, 0);
    chk("mid_rst_instret", instret_o, 0);
    chk("mid_rst_ready", lat_ready_o, 0);
    chk("mid_rst_stall", wb_stall_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    rsn_i = 1'b1;
    apply(idle);
    chk("post_rst_ready", lat_ready_o, 1);
    chk("post_rst_no_drain", rf_we_o, 0);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r.valid     = ($urandom_range(0, 9) < 7);
      r.we        = ($urandom_range(0, 9) < 8);
      r.waddr     = 5'($urandom_range(0, 7));
      r.res       = $urandom;
      r.block     = ($urandom_range(0, 99) < 15);
      r.inject    = ($urandom_range(0, 99) < 10);
      r.lat_valid = ($urandom_range(0, 9) < 4);
      r.lat_waddr = 5'($urandom_range(0, 7));
      r.lat_data  = $urandom;
      apply(r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
